avanco_passos: RTL and testbench
================================

// Module: avanco_passos
// PURPOSE
//   Parametrised multi-step advance controller for the robot. Accepts one
//   advance command (direction + step count), issues one movement action per
//   cell to the motor stage, waits for the motor acknowledge, checks the wall
//   sensor before every step and tracks the robot's (x,y) cell position.
//   Sits between the navigation FSM and the motor/action stage.
// PARAMETERS
//   COORD_W      4   width of pos_x/pos_y; grid is 2**COORD_W cells per axis
//   STEP_W       3   width of passos; max 2**STEP_W-1 steps per command
//   ACK_TIMEOUT  15  max cycles in WAIT_ACK before erro (>=1)
// PORTS
//   clockc3       in   1        system clock, all logic on rising edge
//   reset         in   1        async reset, ACTIVE-LOW (0 = reset)
//   avancar       in   1        command request, sampled only in IDLE
//   orientacao    in   3        001=N 010=O(west) 011=L(east) 100=S
//   passos        in   STEP_W   number of cells to advance
//   parede        in   1        1 = wall directly ahead in current direction
//   motor_pronto  in   1        motor acknowledges completion of current step
//   acao          out  3        action to motor: orientation code or 000=parado
//   ocupado       out  1        1 while a command is in progress (not IDLE)
//   pos_x         out  COORD_W  current x cell
//   pos_y         out  COORD_W  current y cell
//   concluido     out  1        1-cycle pulse: all steps done
//   bloqueado     out  1        1-cycle pulse: command stopped by wall
//   erro          out  1        1-cycle pulse: rejected command or ack timeout
// BEHAVIOUR
//   - Reset (reset=0, async): state=IDLE, acao=000, pos_x=pos_y=0, counters=0,
//     ocupado/concluido/bloqueado/erro=0. Reset mid-command aborts it fully.
//   - All outputs registered. States: IDLE, CHECK, WAIT_ACK.
//   - IDLE: avancar=1 with valid orientacao and passos!=0 -> latch dir,
//     cnt=passos, goto CHECK (ocupado=1 next cycle). avancar=1 with invalid
//     orientacao (000,101..111) or passos=0 -> erro pulse, stay IDLE.
//     avancar=0 -> stay. avancar ignored outside IDLE.
//   - CHECK (1 cycle): parede=1 -> acao=000, bloqueado pulse, goto IDLE,
//     position unchanged. parede=0 -> acao=dir, tmo=0, goto WAIT_ACK.
//   - WAIT_ACK: acao held at dir. motor_pronto=1 -> acao=000, update position,
//     cnt=cnt-1; if cnt was 1 -> concluido pulse, goto IDLE, else goto CHECK.
//     Else tmo++; tmo reaching ACK_TIMEOUT -> acao=000, erro pulse, goto IDLE,
//     position of the unacked step NOT updated.
//   - motor_pronto=1 while not in WAIT_ACK is ignored.
//   - Position update: N y+1, S y-1, L x+1, O x-1; modulo 2**COORD_W
//     (wrap 15->0 and 0->15 for COORD_W=4), no saturation.
//   - Latency: avancar to first acao!=000 = 2 cycles (IDLE->CHECK->WAIT_ACK)
//     when parede=0. Each extra step costs 1 CHECK cycle after the ack.
//   - At most one of concluido/bloqueado/erro is high in any cycle; ocupado=0
//     in the cycle a pulse is visible (already back in IDLE).
// TESTING
//   1. reset=0 mid-WAIT_ACK with acao=001 -> acao=000, pos=(0,0), ocupado=0
//      immediately, no pulses.
//   2. orient=011, passos=3, parede=0, motor_pronto 3 cycles after each acao
//      -> acao=011 three times, pos_x 0->3, one concluido pulse.
//   3. orient=001, passos=5, parede rises before 3rd CHECK -> pos_y=2,
//      bloqueado pulse, acao=000.
//   4. pos=(0,0), orient=010, passos=1 -> pos_x=15 (wrap); then orient=100
//      -> pos_y=15.
//   5. orient=100, passos=2, no motor_pronto -> erro exactly ACK_TIMEOUT
//      cycles after acao=100, pos unchanged.
//   6. orient=111 or passos=0 with avancar=1 -> erro pulse, ocupado stays 0;
//      avancar during busy command has no effect.

Source files
------------

// File: rtl/avanco_passos.sv
// Multi-step advance controller: runs one (direction, step count) command cell by cell,
// checking the wall sensor before each step and tracking the robot's (x,y) cell.
module avanco_passos #(
  parameter int COORD_W     = 4,
  parameter int STEP_W      = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clockc3,
  input  logic               reset,
  input  logic               avancar,
  input  logic [2:0]         orientacao,
  input  logic [STEP_W-1:0]  passos,
  input  logic               parede,
  input  logic               motor_pronto,
  output logic [2:0]         acao,
  output logic               ocupado,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               concluido,
  output logic               bloqueado,
  output logic               erro
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  localparam logic [2:0] PARADO = 3'b000;
  localparam logic [2:0] NORTE  = 3'b001;
  localparam logic [2:0] OESTE  = 3'b010;
  localparam logic [2:0] LESTE  = 3'b011;
  localparam logic [2:0] SUL    = 3'b100;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t            state_reg;
  logic [2:0]        dir_reg;
  logic [STEP_W-1:0] cnt_reg;
  logic [TMO_W-1:0]  tmo_reg;
  logic              orient_ok;

  assign orient_ok = (orientacao != PARADO) && (orientacao <= SUL);

  always_ff @(posedge clockc3 or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      dir_reg   <= PARADO;
      cnt_reg   <= '0;
      tmo_reg   <= '0;
      acao      <= PARADO;
      ocupado   <= 1'b0;
      pos_x     <= '0;
      pos_y     <= '0;
      concluido <= 1'b0;
      bloqueado <= 1'b0;
      erro      <= 1'b0;
    end else begin
      // Outcome flags are single-cycle pulses.
      concluido <= 1'b0;
      bloqueado <= 1'b0;
      erro      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (avancar) begin
            if (orient_ok && (passos != '0)) begin
              dir_reg   <= orientacao;
              cnt_reg   <= passos;
              state_reg <= CHECK;
              ocupado   <= 1'b1;
            end else begin
              erro <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (parede) begin
            acao      <= PARADO;
            bloqueado <= 1'b1;
            ocupado   <= 1'b0;
            state_reg <= IDLE;
          end else begin
            acao      <= dir_reg;
            tmo_reg   <= '0;
            state_reg <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (motor_pronto) begin
            acao <= PARADO;
            case (dir_reg)
              NORTE:   pos_y <= pos_y + COORD_W'(1);
              SUL:     pos_y <= pos_y - COORD_W'(1);
              LESTE:   pos_x <= pos_x + COORD_W'(1);
              OESTE:   pos_x <= pos_x - COORD_W'(1);
              default: ;
            endcase
            cnt_reg <= cnt_reg - STEP_W'(1);
            if (cnt_reg == STEP_W'(1)) begin
              concluido <= 1'b1;
              ocupado   <= 1'b0;
              state_reg <= IDLE;
            end else begin
              state_reg <= CHECK;
            end
          end else if (tmo_reg == TMO_LAST) begin
            // Unacknowledged step: position stays where it was.
            acao      <= PARADO;
            erro      <= 1'b1;
            ocupado   <= 1'b0;
            state_reg <= IDLE;
          end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end
        end
        default: begin
          acao      <= PARADO;
          ocupado   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avanco_passos.sv
// Randomized bench for avanco_passos: each command is planned up front (walls, ack
// delays, timeouts) and the outputs are compared cycle by cycle against a grid model.
module tb_avanco_passos;

  localparam int COORD_W     = 4;
  localparam int STEP_W      = 3;
  localparam int ACK_TIMEOUT = 15;
  localparam int GRID        = 1 << COORD_W;

  logic               clockc3 = 1'b0;
  logic               reset = 1'b0;
  logic               avancar = 1'b0;
  logic [2:0]         orientacao = 3'b000;
  logic [STEP_W-1:0]  passos = '0;
  logic               parede = 1'b0;
  logic               motor_pronto = 1'b0;
  logic [2:0]         acao;
  logic               ocupado;
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic               concluido;
  logic               bloqueado;
  logic               erro;

  int vectors = 0;
  int miscompares = 0;
  int ex = 0;
  int ey = 0;

  avanco_passos #(
    .COORD_W(COORD_W), .STEP_W(STEP_W), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clockc3(clockc3), .reset(reset), .avancar(avancar), .orientacao(orientacao),
    .passos(passos), .parede(parede), .motor_pronto(motor_pronto), .acao(acao),
    .ocupado(ocupado), .pos_x(pos_x), .pos_y(pos_y), .concluido(concluido),
    .bloqueado(bloqueado), .erro(erro)
  );

  always #5 clockc3 = ~clockc3;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input int e_acao, input int e_ocup,
                            input int e_conc, input int e_bloq, input int e_erro);
    check_val({tag, ".acao"}, 32'(acao), e_acao);
    check_val({tag, ".ocupado"}, 32'(ocupado), e_ocup);
    check_val({tag, ".concluido"}, 32'(concluido), e_conc);
    check_val({tag, ".bloqueado"}, 32'(bloqueado), e_bloq);
    check_val({tag, ".erro"}, 32'(erro), e_erro);
    check_val({tag, ".pos_x"}, 32'(pos_x), ex);
    check_val({tag, ".pos_y"}, 32'(pos_y), ey);
  endtask

  task automatic tick;
    @(posedge clockc3);
    #1;
  endtask

  // Grid model: N y+1, S y-1, L(east) x+1, O(west) x-1, all modulo GRID.
  task automatic move_model(input int o);
    case (o)
      1: ey = (ey + 1) % GRID;
      4: ey = (ey + GRID - 1) % GRID;
      3: ex = (ex + 1) % GRID;
      2: ex = (ex + GRID - 1) % GRID;
      default: ;
    endcase
  endtask

  task automatic busy_noise;
    avancar    = 1'($urandom_range(0, 1));
    orientacao = 3'($urandom);
    passos     = STEP_W'($urandom);
    parede     = 1'($urandom_range(0, 1));
  endtask

  // wall_at: step whose check sees a wall (>= p: none); tmo_at: step never acked (-1: none);
  // delay: idle cycles before each ack (-1: random).
  task automatic run_cmd(input int o, input int p, input int wall_at, input int tmo_at,
                         input int delay);
    int d;
    avancar      = 1'b1;
    orientacao   = o[2:0];
    passos       = p[STEP_W-1:0];
    parede       = (wall_at == 0);
    motor_pronto = 1'($urandom_range(0, 1));
    tick;
    avancar = 1'b0;
    if (o < 1 || o > 4 || p == 0) begin
      check_outs("reject", 0, 0, 0, 0, 1);
      parede       = 1'b0;
      motor_pronto = 1'b0;
      return;
    end
    check_outs("start", 0, 1, 0, 0, 0);
    for (int i = 0; i < p; i++) begin
      motor_pronto = 1'($urandom_range(0, 1));
      tick;
      motor_pronto = 1'b0;
      if (wall_at == i) begin
        check_outs("wall", 0, 0, 0, 1, 0);
        parede = 1'b0;
        return;
      end
      check_outs("issue", o, 1, 0, 0, 0);
      if (tmo_at == i) begin
        for (int k = 1; k < ACK_TIMEOUT; k++) begin
          busy_noise();
          tick;
          check_outs("tmo_wait", o, 1, 0, 0, 0);
        end
        avancar = 1'b0;
        tick;
        check_outs("timeout", 0, 0, 0, 0, 1);
        parede = 1'b0;
        return;
      end
      d = (delay < 0) ? int'($urandom_range(0, 4)) : delay;
      for (int k = 0; k < d; k++) begin
        busy_noise();
        tick;
        check_outs("ack_wait", o, 1, 0, 0, 0);
      end
      avancar      = 1'b0;
      motor_pronto = 1'b1;
      parede       = (wall_at == i + 1);
      tick;
      motor_pronto = 1'b0;
      move_model(o);
      if (i == p - 1) check_outs("done", 0, 0, 1, 0, 0);
      else            check_outs("ack", 0, 1, 0, 0, 0);
    end
    parede = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int k = 0; k < n; k++) begin
      motor_pronto = 1'($urandom_range(0, 1));
      parede       = 1'($urandom_range(0, 1));
      tick;
      check_outs("idle", 0, 0, 0, 0, 0);
    end
    motor_pronto = 1'b0;
    parede       = 1'b0;
  endtask

  initial begin
    int o, p, w, t;
    reset = 1'b0;
    tick;
    tick;
    check_outs("reset", 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    tick;
    check_outs("post_reset", 0, 0, 0, 0, 0);

    // East three cells, ack three cycles after each action.
    run_cmd(3, 3, 99, -1, 2);
    idle_gap(2);
    // Rejected commands.
    run_cmd(7, 3, 99, -1, 0);
    run_cmd(1, 0, 99, -1, 0);
    idle_gap(1);
    // North five, wall before the third step.
    run_cmd(1, 5, 2, -1, 1);
    idle_gap(1);

    // Asynchronous reset while the motor is being driven north.
    avancar    = 1'b1;
    orientacao = 3'b001;
    passos     = STEP_W'(2);
    tick;
    avancar = 1'b0;
    tick;
    check_outs("pre_abort", 1, 1, 0, 0, 0);
    #2 reset = 1'b0;
    ex = 0;
    ey = 0;
    #1 check_outs("abort", 0, 0, 0, 0, 0);
    tick;
    reset = 1'b1;
    tick;
    check_outs("after_abort", 0, 0, 0, 0, 0);

    // Wrap-around from the origin.
    run_cmd(2, 1, 99, -1, 0);
    run_cmd(4, 1, 99, -1, 1);
    check_val("wrap.pos_x", 32'(pos_x), 15);
    check_val("wrap.pos_y", 32'(pos_y), 15);
    idle_gap(1);
    // South with no acknowledge at all.
    run_cmd(4, 2, 99, 0, 0);
    idle_gap(1);

    for (int n = 0; n < 150; n++) begin
      o = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 4));
      p = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, (1 << STEP_W) - 1));
      w = (p > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, p - 1)) : p;
      t = (p > 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, p - 1)) : -1;
      run_cmd(o, p, w, t, -1);
      idle_gap(int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
